// File: rtl/seg_red_tree_pipe.sv
// Pipelined, segment-aware binary reduction tree: one register stage per tree level,
// lower-level node results are carried forward so a whole beat's nodes emerge together.
module seg_red_tree_pipe #(
    parameter  int N = 32,
    parameter  int W = 8,
    parameter  int V = 3,
    localparam int S = W + $clog2(N),
    localparam int L = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0][W-1:0]   operands,
    input  logic [N-1:0][V-1:0]   vec_ids,
    input  logic [N-1:0]          lane_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-2:0][S-1:0]   id_sums,
    output logic [N-2:0][V-1:0]   node_ids,
    output logic [N-2:0]          id_valids
);

    logic                adv_s;
    logic [N-1:0][S-1:0] leaf_sum_s;

    // Masked-off lanes contribute zero to every sum.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            if (lane_mask[j]) begin
                leaf_sum_s[j] = {{(S-W){1'b0}}, operands[j]};
            end else begin
                leaf_sum_s[j] = {S{1'b0}};
            end
        end
    end

    for (genvar l = 1; l <= L; l++) begin : g_stage
        localparam int B = N - (N >> (l-1));
        localparam int M = N >> l;

        logic                valid_r;
        logic                valid_s;
        logic [N-2:0][S-1:0] sum_r, sum_s;
        logic [N-2:0][V-1:0] id_r, id_s;
        logic [N-2:0]        uni_r, uni_s;

        if (l == 1) begin : g_leaf
            // Level 1 combines adjacent lanes straight from the input beat.
            always_comb begin
                valid_s = in_valid;
                sum_s   = {((N-1)*S){1'b0}};
                id_s    = {((N-1)*V){1'b0}};
                uni_s   = {(N-1){1'b0}};
                for (int i = 0; i < M; i++) begin
                    sum_s[i] = leaf_sum_s[2*i] + leaf_sum_s[2*i+1];
                    id_s[i]  = vec_ids[2*i];
                    uni_s[i] = lane_mask[2*i] & lane_mask[2*i+1] &
                               (vec_ids[2*i] == vec_ids[2*i+1]);
                end
            end
        end else begin : g_node
            localparam int BP = B - (N >> (l-1));
            // Carry lower levels forward and combine the previous level's node pairs.
            always_comb begin
                valid_s = g_stage[l-1].valid_r;
                sum_s   = {((N-1)*S){1'b0}};
                id_s    = {((N-1)*V){1'b0}};
                uni_s   = {(N-1){1'b0}};
                for (int k = 0; k < B; k++) begin
                    sum_s[k] = g_stage[l-1].sum_r[k];
                    id_s[k]  = g_stage[l-1].id_r[k];
                    uni_s[k] = g_stage[l-1].uni_r[k];
                end
                for (int i = 0; i < M; i++) begin
                    sum_s[B+i] = g_stage[l-1].sum_r[BP+2*i] + g_stage[l-1].sum_r[BP+2*i+1];
                    id_s[B+i]  = g_stage[l-1].id_r[BP+2*i];
                    uni_s[B+i] = g_stage[l-1].uni_r[BP+2*i] & g_stage[l-1].uni_r[BP+2*i+1] &
                                 (g_stage[l-1].id_r[BP+2*i] == g_stage[l-1].id_r[BP+2*i+1]);
                end
            end
        end

        // Stage register: the whole pipeline shifts together or holds together.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r <= 1'b0;
                sum_r   <= {((N-1)*S){1'b0}};
                id_r    <= {((N-1)*V){1'b0}};
                uni_r   <= {(N-1){1'b0}};
            end else if (adv_s) begin
                valid_r <= valid_s;
                sum_r   <= sum_s;
                id_r    <= id_s;
                uni_r   <= uni_s;
            end
        end
    end

    assign adv_s     = out_ready | ~g_stage[L].valid_r;
    assign in_ready  = adv_s;
    assign out_valid = g_stage[L].valid_r;
    assign id_sums   = g_stage[L].sum_r;
    assign node_ids  = g_stage[L].id_r;
    assign id_valids = g_stage[L].uni_r;

endmodule

// File: tb/tb_seg_red_tree_pipe.sv
// Directed self-checking bench for seg_red_tree_pipe at N=8, W=8, V=3.
module tb_seg_red_tree_pipe;
    localparam int N = 8;
    localparam int W = 8;
    localparam int V = 3;
    localparam int S = 11;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] operands;
    logic [N-1:0][V-1:0] vec_ids;
    logic [N-1:0]        lane_mask;
    logic                out_valid;
    logic                out_ready;
    logic [N-2:0][S-1:0] id_sums;
    logic [N-2:0][V-1:0] node_ids;
    logic [N-2:0]        id_valids;

    int n_cmp;
    int n_bad;

    seg_red_tree_pipe #(.N(N), .W(W), .V(V)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operands(operands), .vec_ids(vec_ids), .lane_mask(lane_mask),
        .out_valid(out_valid), .out_ready(out_ready), .id_sums(id_sums),
        .node_ids(node_ids), .id_valids(id_valids)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int first_op, input int op_step, input logic [N-1:0] mask);
        for (int j = 0; j < N; j++) begin
            operands[j] = 8'(first_op + j * op_step);
            vec_ids[j]  = 3'd0;
        end
        lane_mask = mask;
    endtask

    // Present one beat, then wait (bounded) for it to emerge; out_ready held at 1.
    task automatic run_beat(input string tag);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd3);
    endtask

    task automatic check_tree(input string tag, input int es [7], input logic [6:0] ev);
        for (int k = 0; k < N-1; k++) begin
            check_val($sformatf("%s_sum%0d", tag, k), 32'(id_sums[k]), 32'(es[k]));
        end
        check_val({tag, "_valids"}, 32'(id_valids), 32'(ev));
    endtask

    initial begin
        logic [15:0] exp_rdy;
        logic [15:0] exp_ov;
        int sent;
        int rcv;

        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_beat(0, 0, 8'h00);
        #12;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_sums_zero", 32'(id_sums == '0), 32'd1);
        check_val("rst_ids_zero", 32'(node_ids == '0), 32'd1);
        check_val("rst_valids", 32'(id_valids), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Uniform segment
        set_beat(1, 1, 8'hFF);
        run_beat("uni");
        check_tree("uni", '{3, 7, 11, 15, 10, 26, 36}, 7'h7F);

        // Two segments: lanes 4..7 carry id 1
        set_beat(10, 0, 8'hFF);
        for (int j = 4; j < N; j++) vec_ids[j] = 3'd1;
        run_beat("seg2");
        check_tree("seg2", '{20, 20, 20, 20, 40, 40, 80}, 7'h3F);
        check_val("seg2_id5", 32'(node_ids[5]), 32'd1);
        check_val("seg2_id3", 32'(node_ids[3]), 32'd1);
        check_val("seg2_id6", 32'(node_ids[6]), 32'd0);

        // Maximum operand width
        set_beat(255, 0, 8'hFF);
        run_beat("max");
        check_tree("max", '{510, 510, 510, 510, 1020, 1020, 2040}, 7'h7F);

        // Lane 3 masked off
        set_beat(1, 1, 8'hF7);
        run_beat("mask");
        check_tree("mask", '{3, 3, 11, 15, 6, 26, 32}, 7'h2D);

        tick(); tick(); tick();

        // Backpressure: out_ready low for cycles 2..7
        exp_rdy = 16'h030E;
        exp_ov  = 16'h1FF0;
        sent    = 0;
        rcv     = 0;
        for (int c = 1; c <= 14; c++) begin
            out_ready = (c >= 2 && c <= 7) ? 1'b0 : 1'b1;
            in_valid  = (sent < 5) ? 1'b1 : 1'b0;
            set_beat(sent + 1, 0, 8'hFF);
            #1;
            if (c <= 9) check_val($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'(exp_rdy[c]));
            check_val($sformatf("bp_out_valid_c%0d", c), 32'(out_valid), 32'(exp_ov[c]));
            if (c >= 4 && c <= 7) check_val($sformatf("bp_hold_c%0d", c), 32'(id_sums[6]), 32'd8);
            if (out_valid && out_ready) begin
                check_val($sformatf("bp_order%0d", rcv), 32'(id_sums[6]), 32'(8 * (rcv + 1)));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check_val("bp_sent", 32'(sent), 32'd5);
        check_val("bp_rcvd", 32'(rcv), 32'd5);

        // Reset with two beats in flight
        out_ready = 1'b1;
        set_beat(5, 0, 8'hFF);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check_val("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_sums_zero", 32'(id_sums == '0), 32'd1);
        check_val("mid_ids_zero", 32'(node_ids == '0), 32'd1);
        check_val("mid_valids", 32'(id_valids), 32'd0);
        check_val("mid_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val($sformatf("mid_flush_c%0d", c), 32'(out_valid), 32'd0);
        end
        set_beat(1, 1, 8'hFF);
        run_beat("post");
        check_val("post_root", 32'(id_sums[6]), 32'd36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seg_red_tree_pipe.md
# seg_red_tree_pipe

Pipelined, segment-aware reduction tree for the SIGMA distribution/reduction fabric. Each input beat carries N operands, each with a vector ID and a lane-valid mask. The block reduces them through a log2(N)-level binary adder tree with one register stage per level. For every internal node it reports the sum, the vector ID, and a flag that says whether the node's span is one uniform, fully valid vector segment. A valid/ready handshake on both sides lets it stream one beat per cycle under backpressure.

## Interface
Parameters:
- N, 32: operand lanes; a power of 2, at least 2.
- W, 8: operand width in bits (unsigned).
- V, 3: vector-ID width in bits.
- S, W+$clog2(N): width of each node sum; derived, never overridden.
- L, $clog2(N): tree levels, equal to the pipeline depth; derived.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- operands  in  [N-1:0][W-1:0]  lane operands.
- vec_ids  in  [N-1:0][V-1:0]  lane vector IDs.
- lane_mask  in  [N-1:0]  1 means the lane participates.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- id_sums  out  [N-2:0][S-1:0]  node sums.
- node_ids  out  [N-2:0][V-1:0]  node vector IDs.
- id_valids  out  [N-2:0]  node span is a uniform, fully valid segment.

## Operation
Leaf values (lane i):
- sum = operands[i] zero-extended to S bits if lane_mask[i] is 1, otherwise 0.
- id = vec_ids[i].
- uni = lane_mask[i].

Node combine (left child a = index 2i, right child b = index 2i+1):
- sum = a.sum + b.sum, unsigned, S bits. The sum cannot overflow.
- id = a.id.
- uni = a.uni & b.uni & (a.id == b.id).
- The sum is always computed, even when uni is 0.

Output indexing:
- Level l runs from 1 to L. Node i of level l maps to flat index BASE(l)+i, where BASE(l) = N - (N >> (l-1)).
- Index 0 to N/2-1 holds level 1, and so on. Index N-2 is the root.

Pipeline:
- Stage l (1..L) computes level l from the stage l-1 registers and registers the result.
- Each stage also registers its valid bit.
- Results of lower levels are carried forward in delay registers, so all N-1 nodes of one beat appear together at stage L.

Handshake:
- adv = out_ready | ~valid[L].
- in_ready = adv, combinational.
- When adv is 1, every stage shifts: valid[1] <= in_valid, and valid[l] <= valid[l-1].
- When adv is 0, every stage holds. The whole pipeline stalls; bubbles are not compressed.
- A beat is accepted when in_valid & in_ready.
- If in_valid is 0 while adv is 1, a bubble enters (valid bit 0). Data registers may update freely in that case.

Outputs:
- out_valid = valid[L].
- id_sums, node_ids and id_valids are driven from the stage-L registers.
- While out_valid is 1 and out_ready is 0, all outputs hold stable.

## Timing
Reset:
- rst asserted clears every valid bit and every data register to 0 immediately, without waiting for a clock.
- During and after reset: out_valid=0, id_sums=0, node_ids=0, id_valids=0, in_ready=1.
- Beats in flight when reset asserts are discarded; nothing partial is emitted.
- First acceptance is at the first rising edge with rst low.

Latency and throughput:
- A beat accepted at edge t is presented with out_valid=1 after edge t+L-1, i.e. L cycles after acceptance, provided no stall.
- Throughput is one beat per cycle when out_ready is held at 1.

Boundary conditions:
- Simultaneous accept and emit (full pipeline, out_ready=1, in_valid=1): both occur in the same cycle with no bubble.
- Stall: with out_ready=0 and the pipeline full, in_ready=0 and no state changes.
- Each stall cycle adds one cycle to the latency of every beat in flight.
- in_valid may drop at any time and the block creates no beats.
- Beat order is preserved.
- N=2 special case: L=1, single root node at index 0.

## Test plan
All scenarios use N=8, W=8, V=3, so S=11 and L=3.
- **Uniform segment.** One beat with operands 1..8, all ids 0, mask 0xFF, out_ready=1 -> out_valid 3 cycles later. Root (idx 6)=36 with id_valid=1. Level 2 (idx 4,5)=10 and 26. Level 1 (idx 0-3)=3, 7, 11, 15. All id_valids=1.
- **Two segments.** ids 0,0,0,0,1,1,1,1 with all operands 10 -> idx 4=40 (id 0, valid), idx 5=40 (id 1, valid), root=80 with id_valid=0 and node_id 0.
- **Maximum width.** All operands 255, same id, mask 0xFF -> root=2040 with no truncation. Level-1 nodes=510.
- **Masked lane.** Lane 3 masked off, otherwise as the uniform-segment case -> idx 1=3, idx 4=6, root=32. id_valids 1, 4 and 6 are 0; all others are 1.
- **Backpressure.** Stream 5 back-to-back beats with out_ready=0 for cycles 2-7 -> in_ready=0 once 3 beats are in flight. Outputs hold stable while stalled. All 5 beats emerge in order with no loss or duplication.
- **Reset mid-stream.** Assert rst while 2 beats are in flight -> out_valid=0 and all outputs 0 immediately. Those beats are never emitted. A fresh beat after release appears 3 cycles after acceptance.
